// File: rtl/gear_selector_ctrl_if.sv
// ============================================================================
//  Module      : gear_selector_ctrl_if
//  Description : Signal bundle between the panel/vehicle side and the
//                transmission selector controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gear_selector_ctrl_if;
    logic       engine_on;
    logic       tick_speed;
    logic [7:0] speed;
    logic       is_brake_normal;
    logic       is_brake_hard;
    logic       req_valid;
    logic [3:0] req_gear;
    logic       req_ready;
    logic       low_mode_req;
    logic       limit_up;
    logic       limit_down;
    logic [3:0] current_gear;
    logic       is_low_gear_mode;
    logic [2:0] max_gear_limit;
    logic       shift_busy;
    logic       reject;
    logic [2:0] reject_code;

    // Panel / vehicle side
    modport master (
        output engine_on, tick_speed, speed, is_brake_normal, is_brake_hard,
               req_valid, req_gear, low_mode_req, limit_up, limit_down,
        input  req_ready, current_gear, is_low_gear_mode, max_gear_limit,
               shift_busy, reject, reject_code
    );

    // Selector controller side
    modport slave (
        input  engine_on, tick_speed, speed, is_brake_normal, is_brake_hard,
               req_valid, req_gear, low_mode_req, limit_up, limit_down,
        output req_ready, current_gear, is_low_gear_mode, max_gear_limit,
               shift_busy, reject, reject_code
    );
endinterface

`default_nettype wire

// File: rtl/gear_selector_ctrl.sv
// ============================================================================
//  Module      : gear_selector_ctrl
//  Description : P/R/N/D selector sequencer with engine/brake/speed
//                interlocks, timed neutral hold between driving positions,
//                and the manual low-gear limit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gear_selector_ctrl #(
    parameter int SHIFT_DELAY = 2
) (
    input  wire logic            clk,
    input  wire logic            rst,
    gear_selector_ctrl_if.slave  bus
);

    localparam logic [3:0] c_GEAR_P  = 4'd3;
    localparam logic [3:0] c_GEAR_R  = 4'd6;
    localparam logic [3:0] c_GEAR_N  = 4'd9;
    localparam logic [3:0] c_GEAR_D  = 4'd12;
    localparam logic [3:0] c_DELAY   = SHIFT_DELAY[3:0];

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t     state_q,  state_d;
    logic [3:0] cnt_q,    cnt_d;
    logic [3:0] target_q, target_d;
    logic [3:0] gear_q,   gear_d;
    logic       low_q,    low_d;
    logic [2:0] limit_q,  limit_d;
    logic       busy_q,   busy_d;
    logic       ready_q,  ready_d;
    logic       rej_q,    rej_d;
    logic [2:0] code_q,   code_d;
    logic       eng_q;

    logic       brake_w;
    logic       req_legal_w;
    logic [2:0] down_target_w;
    logic       down_blocked_w;
    logic [2:0] load_limit_w;

    // Derived request / limit conditions
    always_comb begin
        brake_w     = bus.is_brake_normal | bus.is_brake_hard;
        req_legal_w = (bus.req_gear == c_GEAR_P) || (bus.req_gear == c_GEAR_R) ||
                      (bus.req_gear == c_GEAR_N) || (bus.req_gear == c_GEAR_D);
        down_target_w  = limit_q - 3'd1;
        down_blocked_w = ((down_target_w == 3'd1) && (bus.speed >= 8'd35)) ||
                         ((down_target_w == 3'd2) && (bus.speed >= 8'd65)) ||
                         ((down_target_w == 3'd3) && (bus.speed >= 8'd95));
        if (bus.speed <= 8'd35)      load_limit_w = 3'd1;
        else if (bus.speed <= 8'd65) load_limit_w = 3'd2;
        else if (bus.speed <= 8'd95) load_limit_w = 3'd3;
        else                         load_limit_w = 3'd6;
    end

    // Next-state: request checks, neutral hold sequencing, low-gear limit
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        gear_d   = gear_q;
        limit_d  = limit_q;
        rej_d    = 1'b0;
        code_d   = code_q;
        low_d    = bus.low_mode_req && (gear_q == c_GEAR_D);

        case (state_q)
            ST_IDLE: begin
                // ready_q only rises once IDLE is settled, so it gates acceptance
                if (bus.req_valid && ready_q) begin
                    if (!req_legal_w) begin
                        rej_d  = 1'b1;
                        code_d = 3'd1;
                    end else if (bus.req_gear == gear_q) begin
                        // same position: nothing to do
                    end else if (!bus.engine_on && (bus.req_gear != c_GEAR_P)) begin
                        rej_d  = 1'b1;
                        code_d = 3'd4;
                    end else if (((gear_q == c_GEAR_P) || (gear_q == c_GEAR_N)) &&
                                 ((bus.req_gear == c_GEAR_R) || (bus.req_gear == c_GEAR_D)) &&
                                 !brake_w) begin
                        rej_d  = 1'b1;
                        code_d = 3'd2;
                    end else if ((bus.speed != 8'd0) &&
                                 ((bus.req_gear == c_GEAR_P) || (bus.req_gear == c_GEAR_R) ||
                                  ((gear_q == c_GEAR_R) && (bus.req_gear == c_GEAR_D)))) begin
                        rej_d  = 1'b1;
                        code_d = 3'd3;
                    end else if ((gear_q == c_GEAR_N) || (bus.req_gear == c_GEAR_N)) begin
                        gear_d = bus.req_gear;
                    end else begin
                        state_d  = ST_HOLD;
                        gear_d   = c_GEAR_N;
                        cnt_d    = 4'd0;
                        target_d = bus.req_gear;
                    end
                end
            end
            ST_HOLD: begin
                // Aborts take precedence over a coincident tick
                if (eng_q && !bus.engine_on) begin
                    state_d = ST_IDLE;
                    gear_d  = c_GEAR_N;
                end else if ((bus.speed != 8'd0) &&
                             ((target_q == c_GEAR_P) || (target_q == c_GEAR_R))) begin
                    state_d = ST_IDLE;
                    gear_d  = c_GEAR_N;
                    rej_d   = 1'b1;
                    code_d  = 3'd3;
                end else if (bus.tick_speed) begin
                    cnt_d = cnt_q + 4'd1;
                    if ((cnt_q + 4'd1) == c_DELAY) begin
                        state_d = ST_IDLE;
                        gear_d  = target_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A shift-path reject owns the reject code when both fire together
        if (low_d && !low_q) begin
            limit_d = load_limit_w;
        end else if (low_q && bus.limit_up && !bus.limit_down) begin
            if (limit_q < 3'd6) limit_d = limit_q + 3'd1;
        end else if (low_q && bus.limit_down && !bus.limit_up && (limit_q > 3'd1)) begin
            if (down_blocked_w) begin
                if (!rej_d) begin
                    rej_d  = 1'b1;
                    code_d = 3'd5;
                end
            end else begin
                limit_d = down_target_w;
            end
        end

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d == ST_HOLD);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            target_q <= c_GEAR_P;
            gear_q   <= c_GEAR_P;
            low_q    <= 1'b0;
            limit_q  <= 3'd1;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            rej_q    <= 1'b0;
            code_q   <= 3'd0;
            eng_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            gear_q   <= gear_d;
            low_q    <= low_d;
            limit_q  <= limit_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            rej_q    <= rej_d;
            code_q   <= code_d;
            eng_q    <= bus.engine_on;
        end
    end

    assign bus.req_ready        = ready_q;
    assign bus.current_gear     = gear_q;
    assign bus.is_low_gear_mode = low_q;
    assign bus.max_gear_limit   = limit_q;
    assign bus.shift_busy       = busy_q;
    assign bus.reject           = rej_q;
    assign bus.reject_code      = code_q;

endmodule

`default_nettype wire

// File: tb/tb_gear_selector_ctrl.sv
// ============================================================================
//  Module      : tb_gear_selector_ctrl
//  Description : Self-checking bench for gear_selector_ctrl: directed
//                scenarios plus randomized traffic against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gear_selector_ctrl;

    localparam int SHIFT_DELAY = 2;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    gear_selector_ctrl_if bus ();

    gear_selector_ctrl #(.SHIFT_DELAY(SHIFT_DELAY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [3:0] m_gear, m_target;
    logic       m_hold, m_low, m_ready, m_rej, m_eng_prev;
    logic [2:0] m_limit, m_code;
    int         m_left;
    int         caps [1:3] = '{35, 65, 95};

    // 0 = accept, -1 = no-op, >0 = reject reason
    function automatic int verdict(int cur, int req, bit eng, bit brk, int spd);
        if (!(req inside {3, 6, 9, 12})) return 1;
        if (req == cur) return -1;
        if (!eng && req != 3) return 4;
        if ((cur == 3 || cur == 9) && (req == 6 || req == 12) && !brk) return 2;
        if (spd != 0 && (req == 3 || req == 6 || (cur == 6 && req == 12))) return 3;
        return 0;
    endfunction

    always @(posedge clk) begin
        int  v;
        int  spd;
        int  newlim;
        bit  low_next;
        spd = int'(bus.speed);
        if (rst) begin
            m_gear = 4'd3; m_target = 4'd3; m_hold = 0; m_low = 0; m_ready = 0;
            m_rej = 0; m_eng_prev = 0; m_limit = 3'd1; m_code = 3'd0; m_left = 0;
        end else begin
            low_next = bus.low_mode_req && (m_gear == 4'd12);
            m_rej = 0;
            if (m_hold) begin
                if (m_eng_prev && !bus.engine_on) begin
                    m_hold = 0; m_gear = 4'd9;
                end else if (spd != 0 && (m_target == 4'd3 || m_target == 4'd6)) begin
                    m_hold = 0; m_gear = 4'd9; m_rej = 1; m_code = 3'd3;
                end else if (bus.tick_speed) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin m_hold = 0; m_gear = m_target; end
                end
            end else if (bus.req_valid && m_ready) begin
                v = verdict(int'(m_gear), int'(bus.req_gear), bus.engine_on,
                            bus.is_brake_normal || bus.is_brake_hard, spd);
                if (v > 0) begin
                    m_rej = 1; m_code = 3'(v);
                end else if (v == 0) begin
                    if (m_gear == 4'd9 || bus.req_gear == 4'd9) m_gear = bus.req_gear;
                    else begin
                        m_hold = 1; m_target = bus.req_gear; m_gear = 4'd9; m_left = SHIFT_DELAY;
                    end
                end
            end
            if (low_next && !m_low) begin
                newlim = 6;
                for (int i = 3; i >= 1; i--) if (spd <= caps[i]) newlim = i;
                m_limit = 3'(newlim);
            end else if (m_low && bus.limit_up && !bus.limit_down) begin
                if (m_limit < 6) m_limit = m_limit + 3'd1;
            end else if (m_low && bus.limit_down && !bus.limit_up && m_limit > 1) begin
                newlim = int'(m_limit) - 1;
                if (newlim <= 3 && spd >= caps[newlim]) begin
                    if (!m_rej) begin m_rej = 1; m_code = 3'd5; end
                end else m_limit = 3'(newlim);
            end
            m_low      = low_next;
            m_ready    = !m_hold;
            m_eng_prev = bus.engine_on;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [3:0] g);
        bus.req_gear  = g;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic tick();
        bus.tick_speed = 1'b1;
        step();
        bus.tick_speed = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.engine_on = 1'b1; bus.tick_speed = 0; bus.speed = 8'd0;
        bus.is_brake_normal = 0; bus.is_brake_hard = 0; bus.req_valid = 0;
        bus.req_gear = 4'd3; bus.low_mode_req = 0; bus.limit_up = 0; bus.limit_down = 0;
        step(); step();
        n_cmp++; if (bus.current_gear !== 4'd3) begin n_bad++; $display("FAIL reset_gear: got %0d expected 3", bus.current_gear); end
        n_cmp++; if (bus.max_gear_limit !== 3'd1) begin n_bad++; $display("FAIL reset_limit: got %0d expected 1", bus.max_gear_limit); end
        n_cmp++; if ({bus.req_ready, bus.is_low_gear_mode, bus.shift_busy, bus.reject, bus.reject_code} !== 7'd0)
            begin n_bad++; $display("FAIL reset_flags: got %b expected 0000000", {bus.req_ready, bus.is_low_gear_mode, bus.shift_busy, bus.reject, bus.reject_code}); end
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.req_ready !== 1'b0) begin n_bad++; $display("FAIL ready_release_cycle: got %b expected 0", bus.req_ready); end
        step();
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_release: got %b expected 1", bus.req_ready); end
    endtask

    task automatic test_brake_interlock();
        request(4'd12);
        n_cmp++; if (bus.reject !== 1'b1 || bus.reject_code !== 3'd2)
            begin n_bad++; $display("FAIL brake_reject: got rej=%b code=%0d expected rej=1 code=2", bus.reject, bus.reject_code); end
        n_cmp++; if (bus.current_gear !== 4'd3) begin n_bad++; $display("FAIL brake_gear: got %0d expected 3", bus.current_gear); end
        step();
        n_cmp++; if (bus.reject !== 1'b0) begin n_bad++; $display("FAIL reject_one_cycle: got %b expected 0", bus.reject); end
    endtask

    task automatic test_hold_shift();
        bus.is_brake_normal = 1'b1;
        request(4'd12);
        bus.is_brake_normal = 1'b0;
        n_cmp++; if (bus.current_gear !== 4'd9 || bus.shift_busy !== 1'b1 || bus.req_ready !== 1'b0)
            begin n_bad++; $display("FAIL hold_entry: got gear=%0d busy=%b ready=%b expected 9/1/0", bus.current_gear, bus.shift_busy, bus.req_ready); end
        step(); step();
        n_cmp++; if (bus.current_gear !== 4'd9) begin n_bad++; $display("FAIL hold_no_tick: got %0d expected 9", bus.current_gear); end
        tick();
        n_cmp++; if (bus.current_gear !== 4'd9 || bus.shift_busy !== 1'b1)
            begin n_bad++; $display("FAIL hold_tick1: got gear=%0d busy=%b expected 9/1", bus.current_gear, bus.shift_busy); end
        tick();
        n_cmp++; if (bus.current_gear !== 4'd12 || bus.shift_busy !== 1'b0 || bus.req_ready !== 1'b1)
            begin n_bad++; $display("FAIL hold_commit: got gear=%0d busy=%b ready=%b expected 12/0/1", bus.current_gear, bus.shift_busy, bus.req_ready); end
    endtask

    task automatic test_speed_rules();
        bus.speed = 8'd40;
        request(4'd6);
        n_cmp++; if (bus.reject !== 1'b1 || bus.reject_code !== 3'd3 || bus.current_gear !== 4'd12)
            begin n_bad++; $display("FAIL d_to_r_moving: got rej=%b code=%0d gear=%0d expected 1/3/12", bus.reject, bus.reject_code, bus.current_gear); end
        request(4'd9);
        n_cmp++; if (bus.current_gear !== 4'd9 || bus.shift_busy !== 1'b0)
            begin n_bad++; $display("FAIL d_to_n_immediate: got gear=%0d busy=%b expected 9/0", bus.current_gear, bus.shift_busy); end
        request(4'd9);
        n_cmp++; if (bus.reject !== 1'b0 || bus.current_gear !== 4'd9)
            begin n_bad++; $display("FAIL n_noop: got rej=%b gear=%0d expected 0/9", bus.reject, bus.current_gear); end
        bus.is_brake_hard = 1'b1;
        request(4'd12);
        bus.is_brake_hard = 1'b0;
        n_cmp++; if (bus.current_gear !== 4'd12) begin n_bad++; $display("FAIL n_to_d_immediate: got %0d expected 12", bus.current_gear); end
    endtask

    task automatic test_low_gear();
        bus.speed = 8'd70;
        bus.low_mode_req = 1'b1;
        step();
        n_cmp++; if (bus.is_low_gear_mode !== 1'b1 || bus.max_gear_limit !== 3'd3)
            begin n_bad++; $display("FAIL low_entry: got low=%b limit=%0d expected 1/3", bus.is_low_gear_mode, bus.max_gear_limit); end
        bus.limit_down = 1'b1; step(); bus.limit_down = 1'b0;
        n_cmp++; if (bus.reject !== 1'b1 || bus.reject_code !== 3'd5 || bus.max_gear_limit !== 3'd3)
            begin n_bad++; $display("FAIL limit_down_blocked: got rej=%b code=%0d limit=%0d expected 1/5/3", bus.reject, bus.reject_code, bus.max_gear_limit); end
        for (int i = 0; i < 5; i++) begin bus.limit_up = 1'b1; step(); bus.limit_up = 1'b0; end
        n_cmp++; if (bus.max_gear_limit !== 3'd6) begin n_bad++; $display("FAIL limit_up_sat: got %0d expected 6", bus.max_gear_limit); end
        bus.limit_up = 1'b1; bus.limit_down = 1'b1; step(); bus.limit_up = 1'b0; bus.limit_down = 1'b0;
        n_cmp++; if (bus.max_gear_limit !== 3'd6 || bus.reject !== 1'b0)
            begin n_bad++; $display("FAIL limit_both: got limit=%0d rej=%b expected 6/0", bus.max_gear_limit, bus.reject); end
        bus.limit_down = 1'b1; step(); bus.limit_down = 1'b0;
        n_cmp++; if (bus.max_gear_limit !== 3'd5) begin n_bad++; $display("FAIL limit_down_ok: got %0d expected 5", bus.max_gear_limit); end
        bus.low_mode_req = 1'b0; step();
        n_cmp++; if (bus.is_low_gear_mode !== 1'b0 || bus.max_gear_limit !== 3'd5)
            begin n_bad++; $display("FAIL low_exit_hold: got low=%b limit=%0d expected 0/5", bus.is_low_gear_mode, bus.max_gear_limit); end
        bus.limit_up = 1'b1; step(); bus.limit_up = 1'b0;
        n_cmp++; if (bus.max_gear_limit !== 3'd5) begin n_bad++; $display("FAIL limit_step_outside_low: got %0d expected 5", bus.max_gear_limit); end
        bus.speed = 8'd0;
    endtask

    task automatic test_abort_engine();
        request(4'd3);
        n_cmp++; if (bus.shift_busy !== 1'b1 || bus.current_gear !== 4'd9)
            begin n_bad++; $display("FAIL hold_to_p: got busy=%b gear=%0d expected 1/9", bus.shift_busy, bus.current_gear); end
        bus.engine_on = 1'b0; step();
        n_cmp++; if (bus.current_gear !== 4'd9 || bus.shift_busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.reject !== 1'b0)
            begin n_bad++; $display("FAIL engine_abort: got gear=%0d busy=%b ready=%b rej=%b expected 9/0/1/0", bus.current_gear, bus.shift_busy, bus.req_ready, bus.reject); end
        bus.engine_on = 1'b1; step();
    endtask

    task automatic test_back_to_back_in_hold();
        request(4'd3);
        n_cmp++; if (bus.current_gear !== 4'd3) begin n_bad++; $display("FAIL n_to_p: got %0d expected 3", bus.current_gear); end
        bus.is_brake_normal = 1'b1; request(4'd6); bus.is_brake_normal = 1'b0;
        request(4'd5);
        n_cmp++; if (bus.reject !== 1'b0 || bus.shift_busy !== 1'b1)
            begin n_bad++; $display("FAIL req_in_hold_dropped: got rej=%b busy=%b expected 0/1", bus.reject, bus.shift_busy); end
        request(4'd12);
        tick(); tick();
        n_cmp++; if (bus.current_gear !== 4'd6 || bus.reject !== 1'b0)
            begin n_bad++; $display("FAIL target_kept: got gear=%0d rej=%b expected 6/0", bus.current_gear, bus.reject); end
    endtask

    task automatic test_speed_abort();
        request(4'd3);
        bus.speed = 8'd10; bus.tick_speed = 1'b1; step(); bus.tick_speed = 1'b0;
        n_cmp++; if (bus.current_gear !== 4'd9 || bus.shift_busy !== 1'b0 || bus.reject !== 1'b1 || bus.reject_code !== 3'd3)
            begin n_bad++; $display("FAIL speed_abort: got gear=%0d busy=%b rej=%b code=%0d expected 9/0/1/3", bus.current_gear, bus.shift_busy, bus.reject, bus.reject_code); end
        bus.speed = 8'd0; step();
    endtask

    task automatic test_rst_mid_hold();
        request(4'd3);
        bus.is_brake_normal = 1'b1; request(4'd12); bus.is_brake_normal = 1'b0;
        n_cmp++; if (bus.shift_busy !== 1'b1) begin n_bad++; $display("FAIL second_hold: got busy=%b expected 1", bus.shift_busy); end
        rst = 1'b1; step(); rst = 1'b0;
        n_cmp++; if (bus.current_gear !== 4'd3 || bus.max_gear_limit !== 3'd1)
            begin n_bad++; $display("FAIL rst_hold_gear: got gear=%0d limit=%0d expected 3/1", bus.current_gear, bus.max_gear_limit); end
        n_cmp++; if ({bus.req_ready, bus.is_low_gear_mode, bus.shift_busy, bus.reject, bus.reject_code} !== 7'd0)
            begin n_bad++; $display("FAIL rst_hold_flags: got %b expected 0000000", {bus.req_ready, bus.is_low_gear_mode, bus.shift_busy, bus.reject, bus.reject_code}); end
        step();
    endtask

    task automatic test_bad_code();
        request(4'd5);
        n_cmp++; if (bus.reject !== 1'b1 || bus.reject_code !== 3'd1 || bus.current_gear !== 4'd3)
            begin n_bad++; $display("FAIL bad_code: got rej=%b code=%0d gear=%0d expected 1/1/3", bus.reject, bus.reject_code, bus.current_gear); end
        step();
    endtask

    task automatic test_random();
        logic [7:0] speeds [0:10];
        logic [3:0] gears  [0:4];
        speeds = '{8'd0, 8'd0, 8'd0, 8'd10, 8'd35, 8'd36, 8'd65, 8'd66, 8'd95, 8'd96, 8'd200};
        gears  = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd0};
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst                 = ($urandom_range(0, 299) == 0);
            bus.engine_on       = ($urandom_range(0, 24) != 0);
            bus.tick_speed      = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0) bus.speed = speeds[$urandom_range(0, 10)];
            bus.is_brake_normal = $urandom_range(0, 1);
            bus.is_brake_hard   = ($urandom_range(0, 3) == 0);
            bus.req_valid       = ($urandom_range(0, 3) == 0);
            gears[4]            = 4'($urandom);
            bus.req_gear        = gears[$urandom_range(0, 4)];
            if ($urandom_range(0, 14) == 0) bus.low_mode_req = ~bus.low_mode_req;
            bus.limit_up        = ($urandom_range(0, 5) == 0);
            bus.limit_down      = ($urandom_range(0, 5) == 0);
            step();
            n_cmp++;
            if ({bus.current_gear, bus.shift_busy, bus.req_ready, bus.is_low_gear_mode,
                 bus.max_gear_limit, bus.reject, bus.reject_code} !==
                {m_gear, m_hold, m_ready, m_low, m_limit, m_rej, m_code}) begin
                n_bad++;
                $display("FAIL rnd cycle %0d: got gear=%0d busy=%b rdy=%b low=%b lim=%0d rej=%b code=%0d expected gear=%0d busy=%b rdy=%b low=%b lim=%0d rej=%b code=%0d",
                         cyc, bus.current_gear, bus.shift_busy, bus.req_ready, bus.is_low_gear_mode,
                         bus.max_gear_limit, bus.reject, bus.reject_code,
                         m_gear, m_hold, m_ready, m_low, m_limit, m_rej, m_code);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_brake_interlock();
        test_hold_shift();
        test_speed_rules();
        test_low_gear();
        test_abort_engine();
        test_back_to_back_in_hold();
        test_speed_abort();
        test_rst_mid_hold();
        test_bad_code();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
